// File: rtl/gpio_pad_ctrl.sv
// Pad-side stage of the gpio block: drives or tri-states each pad, synchronises
// and debounces pad inputs, and raises sticky per-pin edge interrupts.
module gpio_pad_ctrl #(
    parameter int NUM_IO          = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [31:0]           reg_ctrl_i,
    input  logic [31:0]           reg_data_i,
    input  logic [2*NUM_IO-1:0]   irq_mode_i,
    input  logic [NUM_IO-1:0]     irq_clr_i,
    inout  wire  [NUM_IO-1:0]     io_pin,
    output logic [NUM_IO-1:0]     io_in_o,
    output logic [NUM_IO-1:0]     irq_pend_o,
    output logic                  int_o
);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } db_state_t;

    localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [NUM_IO-1:0] w_event;
    logic [NUM_IO-1:0] r_pend;
    logic              r_int;
    logic              w_unused;

    assign w_unused = ^{reg_ctrl_i[31:2*NUM_IO], reg_data_i[31:NUM_IO]};

    for (genvar n = 0; n < NUM_IO; n++) begin : g_pin
        logic [1:0]             w_mode;
        logic                   w_drive;
        logic                   w_active;
        logic                   w_sync;
        logic                   w_fire;
        logic                   w_rise;
        logic                   w_fall;
        logic [SYNC_STAGES-1:0] r_sync;
        db_state_t              r_state;
        logic [CNT_W-1:0]       r_cnt;
        logic                   r_db;

        assign w_mode   = reg_ctrl_i[2*n+1:2*n];
        assign w_drive  = (w_mode == 2'b01);
        assign w_active = (w_mode == 2'b01) || (w_mode == 2'b10);
        assign w_sync   = r_sync[SYNC_STAGES-1];

        assign io_pin[n] = w_drive ? reg_data_i[n] : 1'bz;

        // A new level is accepted on the clock the counter has already seen
        // DEBOUNCE_CYCLES disagreeing samples and the sample still disagrees.
        assign w_fire = w_active && (r_state == ST_COUNT) &&
                        (w_sync != r_db) && (r_cnt == DB_LIMIT);
        assign w_rise = w_fire &  w_sync;
        assign w_fall = w_fire & ~w_sync;

        assign w_event[n] = (w_mode == 2'b10) &&
                            ((w_rise && irq_mode_i[2*n]) || (w_fall && irq_mode_i[2*n+1]));

        assign io_in_o[n] = w_active ? r_db : 1'b0;

        // Off modes park the debouncer and let db shadow the synchronised pad,
        // so switching into input mode never sees a stale level as an edge.
        always_ff @(posedge clk) begin
            if (!rstn) begin
                r_sync  <= '0;
                r_state <= ST_STABLE;
                r_cnt   <= '0;
                r_db    <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], io_pin[n]};
                if (!w_active) begin
                    r_state <= ST_STABLE;
                    r_cnt   <= '0;
                    r_db    <= w_sync;
                end else begin
                    case (r_state)
                        ST_STABLE: begin
                            if (w_sync != r_db) begin
                                r_state <= ST_COUNT;
                                r_cnt   <= CNT_ONE;
                            end
                        end
                        ST_COUNT: begin
                            if (w_sync == r_db) begin
                                r_state <= ST_STABLE;
                                r_cnt   <= '0;
                            end else if (r_cnt == DB_LIMIT) begin
                                r_db    <= w_sync;
                                r_cnt   <= '0;
                                r_state <= ST_STABLE;
                            end else begin
                                r_cnt <= r_cnt + CNT_ONE;
                            end
                        end
                        default: begin
                            r_state <= ST_STABLE;
                            r_cnt   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    // A new event beats a clear arriving on the same clock.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pend <= '0;
            r_int  <= 1'b0;
        end else begin
            r_pend <= w_event | (r_pend & ~irq_clr_i);
            r_int  <= |r_pend;
        end
    end

    assign irq_pend_o = r_pend;
    assign int_o      = r_int;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Self-checking bench for gpio_pad_ctrl: directed scenarios plus randomized
// traffic, all compared every cycle against a behavioural pad/debounce model.
module tb_gpio_pad_ctrl;

    localparam int NIO = 2;
    localparam int SS  = 2;
    localparam int DC  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rstn;
    logic [31:0]          ctrl;
    logic [31:0]          data;
    logic [2*NIO-1:0]     irqMode;
    logic [NIO-1:0]       irqClr;
    logic [NIO-1:0]       padDrv;
    logic [NIO-1:0]       padEn;
    wire  [NIO-1:0]       io_pin;
    logic [NIO-1:0]       ioIn;
    logic [NIO-1:0]       pend;
    logic                 intO;

    for (genvar i = 0; i < NIO; i++) begin : g_pad
        assign io_pin[i] = padEn[i] ? padDrv[i] : 1'bz;
    end

    gpio_pad_ctrl #(
        .NUM_IO(NIO), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .CNT_W(5)
    ) dut (
        .clk(clk), .rstn(rstn), .reg_ctrl_i(ctrl), .reg_data_i(data),
        .irq_mode_i(irqMode), .irq_clr_i(irqClr), .io_pin(io_pin),
        .io_in_o(ioIn), .irq_pend_o(pend), .int_o(intO)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: pad history, accepted level, length of the current
    // run of samples disagreeing with it, and the interrupt flags.
    logic [SS-1:0]  mSync [NIO];
    logic           mDb   [NIO];
    int             mRun  [NIO];
    logic [NIO-1:0] mPend;
    logic           mInt;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkAll(input string tag);
        logic [NIO-1:0] expIo;
        logic [1:0]     mode;
        for (int n = 0; n < NIO; n++) begin
            mode     = ctrl[2*n +: 2];
            expIo[n] = (mode == 2'b01 || mode == 2'b10) ? mDb[n] : 1'b0;
        end
        checkOutput({tag, "_io"},   32'(ioIn), 32'(expIo));
        checkOutput({tag, "_pend"}, 32'(pend), 32'(mPend));
        checkOutput({tag, "_int"},  32'(intO), 32'(mInt));
    endtask

    // One clock: update pad enables, advance the model across the coming
    // posedge, then return at the following negedge.
    task automatic applyStimulus();
        logic [1:0]     mode;
        logic           pad;
        logic           sync;
        logic           ev;
        logic [NIO-1:0] nextPend;
        for (int n = 0; n < NIO; n++) padEn[n] = (ctrl[2*n +: 2] != 2'b01);
        if (!rstn) begin
            for (int n = 0; n < NIO; n++) begin
                mSync[n] = '0;
                mDb[n]   = 1'b0;
                mRun[n]  = 0;
            end
            mPend = '0;
            mInt  = 1'b0;
        end else begin
            nextPend = mPend & ~irqClr;
            for (int n = 0; n < NIO; n++) begin
                mode = ctrl[2*n +: 2];
                pad  = (mode == 2'b01) ? data[n] : padDrv[n];
                sync = mSync[n][SS-1];
                ev   = 1'b0;
                if (mode == 2'b00 || mode == 2'b11) begin
                    mDb[n]  = sync;
                    mRun[n] = 0;
                end else if (sync == mDb[n]) begin
                    mRun[n] = 0;
                end else begin
                    mRun[n]++;
                    if (mRun[n] > DC) begin
                        mDb[n]  = sync;
                        mRun[n] = 0;
                        ev = (mode == 2'b10) && (sync ? irqMode[2*n] : irqMode[2*n+1]);
                    end
                end
                if (ev) nextPend[n] = 1'b1;
                mSync[n] = {mSync[n][SS-2:0], pad};
            end
            mInt  = |mPend;
            mPend = nextPend;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic stepN(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            applyStimulus();
            checkAll("model");
        end
    endtask

    initial begin
        int lat;
        rstn    = 1'b0;
        ctrl    = 32'h0;
        data    = 32'h0;
        irqMode = '0;
        irqClr  = '0;
        padDrv  = '0;
        padEn   = '1;
        @(negedge clk);
        stepN(3);
        checkOutput("rst_io",   32'(ioIn), 32'h0);
        checkOutput("rst_pend", 32'(pend), 32'h0);
        checkOutput("rst_int",  32'(intO), 32'h0);

        // Pin 0 input, pad high through reset: io_in_o rises only after latency
        ctrl      = 32'h2;
        padDrv[0] = 1'b1;
        stepN(1);
        rstn = 1'b1;
        lat  = 0;
        for (int c = 1; c <= 40; c++) begin
            applyStimulus();
            checkAll("t1");
            if (ioIn[0] && lat == 0) lat = c;
        end
        checkOutput("t1_latency_ok", 32'((lat >= SS + DC - 1) && (lat <= SS + DC + 1)), 32'h1);
        checkOutput("t1_io_high", 32'(ioIn[0]), 32'h1);

        // Short glitch rejected even with both-edge interrupts armed
        irqMode   = 4'b0011;
        padDrv[0] = 1'b0;
        stepN(10);
        padDrv[0] = 1'b1;
        stepN(30);
        checkOutput("t2_glitch_io",   32'(ioIn[0]), 32'h1);
        checkOutput("t2_glitch_pend", 32'(pend[0]), 32'h0);
        irqMode   = 4'b0000;
        padDrv[0] = 1'b0;
        stepN(25);
        checkOutput("t2_long_io", 32'(ioIn[0]), 32'h0);

        // Rising-only interrupt
        irqMode   = 4'b0001;
        padDrv[0] = 1'b1;
        stepN(SS + DC);
        checkOutput("t3_pre_pend", 32'(pend[0]), 32'h0);
        stepN(1);
        checkOutput("t3_rise_pend", 32'(pend[0]), 32'h1);
        checkOutput("t3_rise_int0", 32'(intO), 32'h0);
        stepN(1);
        checkOutput("t3_rise_int1", 32'(intO), 32'h1);
        irqClr[0] = 1'b1;
        stepN(1);
        irqClr[0] = 1'b0;
        stepN(2);
        padDrv[0] = 1'b0;
        stepN(25);
        checkOutput("t3_fall_nopend", 32'(pend[0]), 32'h0);
        irqMode   = 4'b0011;
        padDrv[0] = 1'b1;
        stepN(25);
        checkOutput("t3_both_rise", 32'(pend[0]), 32'h1);
        irqClr[0] = 1'b1;
        stepN(1);
        irqClr[0] = 1'b0;
        padDrv[0] = 1'b0;
        stepN(25);
        checkOutput("t3_both_fall", 32'(pend[0]), 32'h1);
        irqClr[0] = 1'b1;
        stepN(1);
        irqClr[0] = 1'b0;
        stepN(2);

        // Clear on the same clock as a new event: set wins
        padDrv[0] = 1'b1;
        stepN(SS + DC);
        irqClr[0] = 1'b1;
        stepN(1);
        irqClr[0] = 1'b0;
        checkOutput("t4_race_pend", 32'(pend[0]), 32'h1);
        stepN(1);
        irqClr[0] = 1'b1;
        stepN(1);
        irqClr[0] = 1'b0;
        checkOutput("t4_clr_pend", 32'(pend[0]), 32'h0);
        stepN(1);
        checkOutput("t4_clr_int", 32'(intO), 32'h0);

        // Output mode loopback, then hand the pad back as an input
        ctrl    = 32'h1;
        data[0] = 1'b0;
        stepN(25);
        data[0] = 1'b1;
        stepN(25);
        checkOutput("t5_pad", 32'(io_pin[0]), 32'h1);
        checkOutput("t5_io",  32'(ioIn[0]), 32'h1);
        checkOutput("t5_pend", 32'(pend[0]), 32'h0);
        padDrv[0] = 1'b1;
        ctrl      = 32'h2;
        stepN(25);
        checkOutput("t5_switch_pend", 32'(pend[0]), 32'h0);

        // Off mode, then mid-count reset
        ctrl = 32'h0;
        stepN(1);
        checkOutput("t6_off_io", 32'(ioIn[0]), 32'h0);
        padDrv[0] = 1'b0;
        stepN(25);
        padDrv[0] = 1'b1;
        stepN(25);
        checkOutput("t6_off_pend", 32'(pend[0]), 32'h0);
        ctrl = 32'h2;
        stepN(5);
        checkOutput("t6_enter_io",   32'(ioIn[0]), 32'h1);
        checkOutput("t6_enter_pend", 32'(pend[0]), 32'h0);
        padDrv[0] = 1'b0;
        stepN(25);
        checkOutput("t6_arm_pend", 32'(pend[0]), 32'h1);
        padDrv[0] = 1'b1;
        stepN(8);
        rstn = 1'b0;
        stepN(1);
        checkOutput("t6_rst_io",   32'(ioIn), 32'h0);
        checkOutput("t6_rst_pend", 32'(pend), 32'h0);
        checkOutput("t6_rst_int",  32'(intO), 32'h0);
        rstn = 1'b1;
        stepN(25);

        // Randomized traffic on both pins
        for (int c = 0; c < 2000; c++) begin
            for (int n = 0; n < NIO; n++) begin
                if ($urandom_range(0, 39) == 0) ctrl[2*n +: 2] = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 24) == 0) padDrv[n] = ~padDrv[n];
                if ($urandom_range(0, 24) == 0) data[n] = ~data[n];
                irqClr[n] = ($urandom_range(0, 9) == 0);
            end
            if ($urandom_range(0, 59) == 0) irqMode = 4'($urandom_range(0, 15));
            rstn = ($urandom_range(0, 399) != 0);
            applyStimulus();
            checkAll("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
